// File: rtl/stopwatch_control.sv
// Stopwatch control front end: synchronises and debounces three buttons, runs an
// IDLE/RUNNING/PAUSED FSM, and emits count / pause / clear signals for the digit counter.
module stopwatch_control #(
  parameter int TICK_DIV        = 10,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_start_resume,
  input  logic       btn_stop,
  input  logic       btn_reset,
  output logic       start_resume,
  output logic       stop,
  output logic       reset,
  output logic [1:0] state
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10
  } state_e;

  // Button vector order: bit 0 start/resume, bit 1 stop, bit 2 reset.
  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] deb;
  logic [2:0] deb_q;
  logic [2:0] press;

  assign raw = {btn_reset, btn_stop, btn_start_resume};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb_q <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
    end
  end

  for (genvar b = 0; b < 3; b++) begin : g_btn
    logic [CW-1:0] cnt;
    logic          level;

    // Counter only advances while the synchronised level disagrees, so short glitches reset it.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (sync2[b] != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2[b];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end

    assign deb[b] = level;
  end

  assign press = deb & ~deb_q;

  logic start_ev;
  logic stop_ev;
  logic rst_ev;
  assign start_ev = press[0];
  assign stop_ev  = press[1];
  assign rst_ev   = press[2];

  state_e        state_q;
  state_e        state_d;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          pulse_d;
  logic          clear_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      start_resume <= 1'b0;
      stop         <= 1'b0;
      reset        <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      start_resume <= pulse_d;
      stop         <= (state_d == PAUSED);
      reset        <= clear_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    pulse_d = 1'b0;
    clear_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_ev) begin
          clear_d = 1'b1;
          presc_d = '0;
        end else if (start_ev) begin
          state_d = RUNNING;
        end
      end
      RUNNING: begin
        // The edge that leaves for PAUSED still counts, so a wrap there keeps its pulse.
        if (presc_q == PRE_LAST) begin
          presc_d = '0;
          pulse_d = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
        if (rst_ev) begin
          state_d = IDLE;
          clear_d = 1'b1;
          pulse_d = 1'b0;
          presc_d = '0;
        end else if (stop_ev) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (rst_ev) begin
          state_d = IDLE;
          clear_d = 1'b1;
          presc_d = '0;
        end else if (start_ev) begin
          state_d = RUNNING;
        end
      end
      default: begin
        state_d = IDLE;
        clear_d = 1'b1;
        presc_d = '0;
      end
    endcase
  end

  assign state = state_q;

endmodule
